// File: rtl/stream_packer_pkg.sv
// Shared types and helpers for the stream byte packer.
package stream_packer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        FULL,
        STALL
    } state_t;

    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_byte_packer_if.sv
// Byte-in / word-out ready-valid bundle; slave is the packer, master the surrounding logic.
interface stream_byte_packer_if #(
    parameter int NUM_BYTES = 4
) ();
    logic                   i_valid_i;
    logic [7:0]             i_data_i;
    logic                   i_last_i;
    logic                   i_ready_o;
    logic                   e_valid_o;
    logic [8*NUM_BYTES-1:0] e_data_o;
    logic [NUM_BYTES-1:0]   e_strb_o;
    logic                   e_last_o;
    logic                   e_ready_i;

    modport slave (
        input  i_valid_i, i_data_i, i_last_i, e_ready_i,
        output i_ready_o, e_valid_o, e_data_o, e_strb_o, e_last_o
    );

    modport master (
        output i_valid_i, i_data_i, i_last_i, e_ready_i,
        input  i_ready_o, e_valid_o, e_data_o, e_strb_o, e_last_o
    );
endinterface

// File: rtl/stream_packer_slot.sv
// Output word register with IDLE/FULL/STALL control; input ready comes from state alone.
module stream_packer_slot
    import stream_packer_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        done,
    input  logic [BYTE_W*NUM_BYTES-1:0] cand_data,
    input  logic [NUM_BYTES-1:0]        cand_strb,
    input  logic                        cand_last,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [BYTE_W*NUM_BYTES-1:0] out_data,
    output logic [NUM_BYTES-1:0]        out_strb,
    output logic                        out_last,
    output logic                        in_ready,
    output logic                        take
);
    state_t state, state_next;
    logic   out_xfer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            out_data <= '0;
            out_strb <= '0;
            out_last <= 1'b0;
        end else begin
            state <= state_next;
            if (take) begin
                out_data <= cand_data;
                out_strb <= cand_strb;
                out_last <= cand_last;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (done) state_next = FULL;
            FULL: begin
                if (done && !out_xfer)      state_next = STALL;
                else if (!done && out_xfer) state_next = IDLE;
            end
            STALL:   if (out_xfer) state_next = FULL;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state != IDLE);
        in_ready  = (state != STALL);
        out_xfer  = out_valid & out_ready;
        take      = 1'b0;
        case (state)
            IDLE:    take = done;
            FULL:    take = done & out_xfer;
            STALL:   take = out_xfer;
            default: take = 1'b0;
        endcase
    end
endmodule

// File: rtl/stream_byte_packer.sv
// Packs a byte stream into NUM_BYTES-wide words with strobes and early termination.
// Optional idle flush of partial words: define STREAM_PACKER_TIMEOUT_EN.
module stream_byte_packer
    import stream_packer_pkg::*;
#(
    parameter int NUM_BYTES      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    stream_byte_packer_if.slave  bus
);
    localparam int LW = lane_w(NUM_BYTES);

    if (NUM_BYTES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("stream_byte_packer: NUM_BYTES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    logic [LW-1:0]               cnt;
    logic [BYTE_W*NUM_BYTES-1:0] acc_data, cand_data;
    logic [NUM_BYTES-1:0]        acc_strb, cand_strb;
    logic                        acc_last, cand_last;
    logic                        in_xfer, timeout, done, take;

    assign in_xfer = bus.i_valid_i & bus.i_ready_o;

`ifdef STREAM_PACKER_TIMEOUT_EN
    localparam int TW = lane_w(TIMEOUT_CYCLES);
    logic [TW-1:0] idle_cnt;

    assign timeout = (cnt != '0) && !in_xfer && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                             idle_cnt <= '0;
        else if (in_xfer || cnt == '0 || timeout) idle_cnt <= '0;
        else                                    idle_cnt <= idle_cnt + TW'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    // Candidate word = accumulator merged with the byte arriving this cycle.
    always_comb begin
        cand_data = acc_data;
        cand_strb = acc_strb;
        cand_last = acc_last | timeout;
        if (in_xfer) begin
            for (int unsigned k = 0; k < NUM_BYTES; k++) begin
                if (cnt == LW'(k)) begin
                    cand_data[BYTE_W*k +: BYTE_W] = bus.i_data_i;
                    cand_strb[k]                  = 1'b1;
                end
            end
            cand_last = bus.i_last_i;
        end
    end

    assign done = (in_xfer && (bus.i_last_i || cnt == LW'(NUM_BYTES - 1))) || timeout;

    // A completed word the slot cannot take stays in the accumulator until drained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            acc_data <= '0;
            acc_strb <= '0;
            acc_last <= 1'b0;
        end else begin
            if (done)         cnt <= '0;
            else if (in_xfer) cnt <= cnt + LW'(1);

            if (take) begin
                acc_data <= '0;
                acc_strb <= '0;
                acc_last <= 1'b0;
            end else if (in_xfer || timeout) begin
                acc_data <= cand_data;
                acc_strb <= cand_strb;
                acc_last <= cand_last;
            end
        end
    end

    stream_packer_slot #(
        .NUM_BYTES(NUM_BYTES)
    ) u_slot (
        .clk       (clk),
        .reset     (reset),
        .done      (done),
        .cand_data (cand_data),
        .cand_strb (cand_strb),
        .cand_last (cand_last),
        .out_ready (bus.e_ready_i),
        .out_valid (bus.e_valid_o),
        .out_data  (bus.e_data_o),
        .out_strb  (bus.e_strb_o),
        .out_last  (bus.e_last_o),
        .in_ready  (bus.i_ready_o),
        .take      (take)
    );
endmodule

// File: tb/tb_stream_byte_packer.sv
// Directed self-checking bench for stream_byte_packer (NUM_BYTES=4).
module tb_stream_byte_packer;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    stream_byte_packer_if #(.NUM_BYTES(4)) bus ();

    stream_byte_packer #(
        .NUM_BYTES      (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        bus.i_valid_i = v;
        bus.i_data_i  = d;
        bus.i_last_i  = l;
    endtask

    task automatic test_reset();
        drive(1'b0, 8'h00, 1'b0);
        bus.e_ready_i = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (bus.i_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.i_ready_o); end
        checks++; if (bus.e_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.e_valid_o); end
        checks++; if (bus.e_data_o !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.e_data_o); end
        checks++; if (bus.e_strb_o !== 4'h0 || bus.e_last_o !== 1'b0) begin errors++; $display("FAIL reset_strb_last got=%h/%b exp=0/0", bus.e_strb_o, bus.e_last_o); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_word();
        logic [7:0] b [4];
        b = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.e_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, b[i], 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        checks++; if (bus.e_valid_o !== 1'b1 || bus.e_data_o !== 32'h44332211) begin errors++; $display("FAIL full_word_data got=%b/%h exp=1/44332211", bus.e_valid_o, bus.e_data_o); end
        checks++; if (bus.e_strb_o !== 4'hF || bus.e_last_o !== 1'b0) begin errors++; $display("FAIL full_word_strb got=%h/%b exp=f/0", bus.e_strb_o, bus.e_last_o); end
        tick();
        checks++; if (bus.e_valid_o !== 1'b0) begin errors++; $display("FAIL full_word_drain got=%b exp=0", bus.e_valid_o); end
    endtask

    task automatic test_last();
        bus.e_ready_i = 1'b1;
        drive(1'b1, 8'hAA, 1'b0); tick();
        drive(1'b1, 8'hBB, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b1);
        checks++; if (bus.e_data_o !== 32'h0000BBAA || bus.e_strb_o !== 4'h3 || bus.e_last_o !== 1'b1) begin errors++; $display("FAIL last_word got=%h/%h/%b exp=0000bbaa/3/1", bus.e_data_o, bus.e_strb_o, bus.e_last_o); end
        tick();
        // last asserted with valid low must not close anything
        checks++; if (bus.e_valid_o !== 1'b0) begin errors++; $display("FAIL last_ignored got=%b exp=0", bus.e_valid_o); end
        drive(1'b1, 8'hCC, 1'b0); tick();
        drive(1'b1, 8'hDD, 1'b0); tick();
        drive(1'b1, 8'hEE, 1'b0); tick();
        drive(1'b1, 8'hFF, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0);
        checks++; if (bus.e_data_o !== 32'hFFEEDDCC || bus.e_strb_o !== 4'hF || bus.e_last_o !== 1'b0) begin errors++; $display("FAIL after_last got=%h/%h/%b exp=ffeeddcc/f/0", bus.e_data_o, bus.e_strb_o, bus.e_last_o); end
        tick();
        drive(1'b1, 8'h77, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0);
        checks++; if (bus.e_data_o !== 32'h00000077 || bus.e_strb_o !== 4'h1 || bus.e_last_o !== 1'b1) begin errors++; $display("FAIL lane0_last got=%h/%h/%b exp=00000077/1/1", bus.e_data_o, bus.e_strb_o, bus.e_last_o); end
        tick();
    endtask

    task automatic test_stall();
        bus.e_ready_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        checks++; if (bus.i_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b exp=0", bus.i_ready_o); end
        checks++; if (bus.e_valid_o !== 1'b1 || bus.e_data_o !== 32'h04030201) begin errors++; $display("FAIL stall_hold got=%b/%h exp=1/04030201", bus.e_valid_o, bus.e_data_o); end
        drive(1'b1, 8'h99, 1'b0);
        tick();
        tick();
        drive(1'b0, 8'h00, 1'b0);
        checks++; if (bus.e_data_o !== 32'h04030201 || bus.e_strb_o !== 4'hF || bus.i_ready_o !== 1'b0) begin errors++; $display("FAIL stall_stable got=%h/%h/%b exp=04030201/f/0", bus.e_data_o, bus.e_strb_o, bus.i_ready_o); end
        bus.e_ready_i = 1'b1;
        tick();
        bus.e_ready_i = 1'b0;
        checks++; if (bus.e_valid_o !== 1'b1 || bus.e_data_o !== 32'h08070605 || bus.i_ready_o !== 1'b1) begin errors++; $display("FAIL stall_release got=%b/%h/%b exp=1/08070605/1", bus.e_valid_o, bus.e_data_o, bus.i_ready_o); end
        tick();
        checks++; if (bus.e_valid_o !== 1'b1 || bus.e_data_o !== 32'h08070605) begin errors++; $display("FAIL stall_second_hold got=%b/%h exp=1/08070605", bus.e_valid_o, bus.e_data_o); end
        bus.e_ready_i = 1'b1;
        tick();
        checks++; if (bus.e_valid_o !== 1'b0) begin errors++; $display("FAIL stall_drain got=%b exp=0", bus.e_valid_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_word;
        bus.e_ready_i = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            if (c <= 12) drive(1'b1, 8'hA0 + 8'(c - 1), 1'b0);
            else         drive(1'b0, 8'h00, 1'b0);
            tick();
            checks++; if (bus.i_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready tick=%0d got=%b exp=1", c, bus.i_ready_o); end
            if (c % 4 == 0) begin
                exp_word = {8'hA0 + 8'(c - 1), 8'hA0 + 8'(c - 2), 8'hA0 + 8'(c - 3), 8'hA0 + 8'(c - 4)};
                checks++; if (bus.e_valid_o !== 1'b1 || bus.e_data_o !== exp_word) begin errors++; $display("FAIL b2b_word tick=%0d got=%b/%h exp=1/%h", c, bus.e_valid_o, bus.e_data_o, exp_word); end
            end else begin
                checks++; if (bus.e_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_gap tick=%0d got=%b exp=0", c, bus.e_valid_o); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.e_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'h50 + 8'(i), 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.e_valid_o !== 1'b0 || bus.e_data_o !== 32'h0 || bus.e_strb_o !== 4'h0 || bus.i_ready_o !== 1'b1) begin errors++; $display("FAIL reset_mid got=%b/%h/%h/%b exp=0/0/0/1", bus.e_valid_o, bus.e_data_o, bus.e_strb_o, bus.i_ready_o); end
        tick();
        rst_n = 1'b1;
        bus.e_ready_i = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hC0 + 8'(i), 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        checks++; if (bus.e_data_o !== 32'hC3C2C1C0 || bus.e_strb_o !== 4'hF || bus.e_valid_o !== 1'b1) begin errors++; $display("FAIL reset_clean_word got=%b/%h/%h exp=1/c3c2c1c0/f", bus.e_valid_o, bus.e_data_o, bus.e_strb_o); end
        tick();
    endtask

    task automatic test_timeout();
        int wait_ticks;
        bus.e_ready_i = 1'b1;
        drive(1'b1, 8'h5A, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        wait_ticks = 0;
        while (bus.e_valid_o !== 1'b1 && wait_ticks < 40) begin
            tick();
            wait_ticks++;
        end
`ifdef STREAM_PACKER_TIMEOUT_EN
        checks++; if (wait_ticks !== 16) begin errors++; $display("FAIL timeout_delay got=%0d exp=16", wait_ticks); end
        checks++; if (bus.e_data_o !== 32'h0000005A || bus.e_strb_o !== 4'h1 || bus.e_last_o !== 1'b1) begin errors++; $display("FAIL timeout_word got=%h/%h/%b exp=0000005a/1/1", bus.e_data_o, bus.e_strb_o, bus.e_last_o); end
        tick();
`else
        checks++; if (wait_ticks !== 40) begin errors++; $display("FAIL no_timeout got=%0d exp=40", wait_ticks); end
        drive(1'b1, 8'h00, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        checks++; if (bus.e_data_o !== 32'h0000005A || bus.e_strb_o !== 4'h3 || bus.e_last_o !== 1'b1) begin errors++; $display("FAIL partial_close got=%h/%h/%b exp=0000005a/3/1", bus.e_data_o, bus.e_strb_o, bus.e_last_o); end
        tick();
`endif
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        bus.e_ready_i = 1'b0;
        #2;
        test_reset();
        test_full_word();
        test_last();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stream_byte_packer.md
Name: stream_byte_packer

Overview:
- Ready/valid consumer that receives an 8-bit byte stream and packs it into NUM_BYTES-wide words for a downstream ready/valid sink.
- Sits on the egress side of the byte skid buffer and forms the receiving end of that byte interface.
- Supports early word termination via a last flag, with byte strobes.
- i_ready_o is driven only from flops, so there is no combinational ready path from e_ready_i to i_ready_o.

Parameters:
- NUM_BYTES, 4, bytes per output word; must be >= 2.
- TIMEOUT_CYCLES, 16, idle cycles before a partial word is flushed; used only with STREAM_PACKER_TIMEOUT_EN.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_valid_i  input  1  input byte valid.
- i_data_i  input  8  input byte.
- i_last_i  input  1  byte closes the current word early.
- i_ready_o  output  1  packer accepts a byte.
- e_valid_o  output  1  output word valid.
- e_data_o  output  8*NUM_BYTES  packed word; byte k occupies bits [8k+7:8k].
- e_strb_o  output  NUM_BYTES  per-byte valid strobe.
- e_last_o  output  1  word was closed by i_last_i (or by timeout).
- e_ready_i  input  1  sink accepts the word.

Behaviour:
- Reset (reset low, asynchronous):
  - i_ready_o=1, e_valid_o=0, e_data_o=0, e_strb_o=0, e_last_o=0.
  - Byte counter = 0; state = IDLE; accumulator cleared.
- Transfers:
  - Input transfer when i_valid_i & i_ready_o.
  - Output transfer when e_valid_o & e_ready_i.
- Accumulator:
  - The accepted byte is written to lane cnt and its strobe bit is set; cnt increments.
  - A byte completes the word when cnt==NUM_BYTES-1 or i_last_i=1. On completion cnt wraps to 0.
  - Lanes with strobe 0 are driven 0.
- Output slot state machine:
  - IDLE: slot empty. On completion, the word moves to the slot next cycle -> FULL.
  - FULL: slot valid, accumulator free.
    - Completion with an output transfer in the same cycle: new word replaces slot, stay FULL.
    - Completion without a transfer: word held in accumulator -> STALL.
    - Output transfer without completion -> IDLE.
  - STALL: completed word waiting, i_ready_o=0. On output transfer, the waiting word moves to the slot -> FULL.
- i_ready_o = (state != STALL), from registered state only.
- Latency: 1 cycle from the completing input byte to e_valid_o.
- Throughput: one word per NUM_BYTES input cycles with e_ready_i held high. No bubbles between words.
- e_data_o, e_strb_o and e_last_o are stable while e_valid_o=1 and e_ready_i=0.
- i_last_i on lane 0 produces a single-byte word: e_strb_o = 0b0001.
- i_last_i is ignored when i_valid_i=0.
- Reset asserted mid-word discards the partial word and the slot contents; no output is produced for them.

Optional Feature:
- STREAM_PACKER_TIMEOUT_EN defined:
  - A counter tracks cycles with cnt!=0 and no input transfer.
  - When it reaches TIMEOUT_CYCLES, the partial word completes as if i_last_i were set (e_last_o=1).
  - The counter clears on any input transfer.
  - If the completion stalls, the normal STALL rules apply.
- Undefined: no timer logic; partial words wait indefinitely for more bytes or i_last_i.

Decomposition:
- Package stream_packer_pkg:
  - state_t enum {IDLE, FULL, STALL}.
  - Lane index width function: $clog2(NUM_BYTES).
  - Byte width constant: 8.
- One natural sub-module: stream_packer_slot, holding the output register, the state machine and the ready generation. The accumulator and counter stay in the top level.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 back-to-back, e_ready_i=1 -> one cycle after the 0x44 transfer: e_data_o=0x44332211, e_strb_o=0xF, e_last_o=0.
- Bytes 0xAA,0xBB with i_last_i on 0xBB -> e_data_o=0x0000BBAA, e_strb_o=0x3, e_last_o=1; next word starts at lane 0.
- e_ready_i=0, then 8 bytes sent -> first word held stable; second word completes, i_ready_o=0 (STALL); e_ready_i=1 for one cycle -> second word appears next cycle and i_ready_o returns to 1.
- 12 continuous bytes with e_ready_i=1 -> 3 words on cycles 5, 9 and 13; i_ready_o stays 1 throughout.
- reset pulsed low after 2 bytes -> all outputs return to reset values immediately; next 4 bytes form a clean word with strobe 0xF.
- With STREAM_PACKER_TIMEOUT_EN, one byte 0x5A then idle -> 16 idle cycles later a word with e_data_o=0x0000005A, e_strb_o=0x1, e_last_o=1 is presented.
